// File: rtl/converter_channel_scheduler_pkg.sv
// Shared types and constants for the converter channel scheduler.
// The optional over-voltage guard is enabled with `define CONV_SCHED_OV_GUARD_EN.
package converter_sched_pkg;

    localparam int DEF_NCH        = 4;
    localparam int DEF_DW         = 8;
    localparam int DEF_SETTLE_CYC = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } sched_state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/converter_channel_scheduler_if.sv
// Bundle of source, converter and downstream signals of the scheduler.
// master = scheduler side, slave = surrounding front-ends / converter / sink.
interface converter_channel_scheduler_if #(
    parameter int NCH = converter_sched_pkg::DEF_NCH,
    parameter int DW  = converter_sched_pkg::DEF_DW
);
    localparam int CW = converter_sched_pkg::cw_of(NCH);

    logic [NCH-1:0]    ch_req;
    logic [NCH*DW-1:0] ch_data;
    logic [NCH-1:0]    ch_ack;
    logic              conv_en;
    logic [DW-1:0]     conv_in;
    logic [DW-1:0]     conv_out;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic              out_ready;
    logic              busy;
    logic [NCH-1:0]    ov_fault;

    modport master (
        input  ch_req, ch_data, conv_out, out_ready,
        output ch_ack, conv_en, conv_in, out_valid, out_data, out_ch, busy, ov_fault
    );

    modport slave (
        output ch_req, ch_data, conv_out, out_ready,
        input  ch_ack, conv_en, conv_in, out_valid, out_data, out_ch, busy, ov_fault
    );

endinterface

// File: rtl/converter_channel_scheduler_rr_arbiter.sv
// Combinational rotate-priority arbiter: picks the first eligible
// requester strictly after 'last', wrapping from NCH-1 to 0.
module rr_arbiter
    import converter_sched_pkg::*;
#(
    parameter int NCH = DEF_NCH
) (
    input  logic [NCH-1:0]          req,
    input  logic [NCH-1:0]          mask,
    input  logic [cw_of(NCH)-1:0]   last,
    output logic [cw_of(NCH)-1:0]   grant_idx,
    output logic                    any
);
    localparam int CW = cw_of(NCH);

    logic [NCH-1:0] elig;
    int             idx;

    // Scan from farthest to nearest so the nearest eligible channel after 'last' wins.
    always_comb begin
        elig      = req & ~mask;
        any       = |elig;
        grant_idx = last;
        idx       = 0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(last) + k) % NCH;
            if (elig[idx]) begin
                grant_idx = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/converter_channel_scheduler.sv
// Time-shares one converter between NCH source channels: round-robin grant,
// settle wait, capture, then valid/ready hand-off downstream.
// Optional feature: `define CONV_SCHED_OV_GUARD_EN flags and masks channels
// whose converted value exceeds OV_LIMIT.
module converter_channel_scheduler
    import converter_sched_pkg::*;
#(
    parameter int            NCH        = DEF_NCH,
    parameter int            DW         = DEF_DW,
    parameter int            SETTLE_CYC = DEF_SETTLE_CYC,
    parameter logic [DW-1:0] OV_LIMIT   = DW'(200)
) (
    input logic                          clk,
    input logic                          rst,
    converter_channel_scheduler_if.master bus
);
    localparam int CW    = cw_of(NCH);
    // Counter is loaded with SETTLE_CYC so the capture edge lands
    // SETTLE_CYC+1 edges after the grant edge.
    localparam int CNT_W = cw_of(SETTLE_CYC + 1);

`ifdef CONV_SCHED_OV_GUARD_EN
    localparam bit OV_GUARD = 1'b1;
`else
    localparam bit OV_GUARD = 1'b0;
`endif

    sched_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CW-1:0]  last_q, last_d;
    logic [DW-1:0]  conv_in_q, conv_in_d;
    logic [NCH-1:0] ack_q, ack_d;
    logic           conv_en_q, conv_en_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic [CW-1:0]  out_ch_q, out_ch_d;
    logic [NCH-1:0] ov_q, ov_d;

    logic [NCH-1:0] arb_mask;
    logic [CW-1:0]  grant_idx;
    logic           grant_any;
    logic           settle_done;
    logic           ov_hit;

    assign arb_mask    = OV_GUARD ? ov_q : '0;
    assign settle_done = (cnt_q == '0);
    assign ov_hit      = OV_GUARD && (bus.conv_out > OV_LIMIT);

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (bus.ch_req),
        .mask      (arb_mask),
        .last      (last_q),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= CW'(NCH - 1);
            conv_in_q   <= '0;
            ack_q       <= '0;
            conv_en_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ov_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            conv_in_q   <= conv_in_d;
            ack_q       <= ack_d;
            conv_en_q   <= conv_en_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ov_q        <= ov_d;
        end
    end

    // Next-state logic: IDLE -> SETTLE -> HOLD -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any)     state_d = SETTLE;
            SETTLE:  if (settle_done)   state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Register updates per state: grant/latch, settle count, capture, release.
    always_comb begin
        cnt_d       = cnt_q;
        last_d      = last_q;
        conv_in_d   = conv_in_q;
        ack_d       = '0;
        conv_en_d   = conv_en_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ov_d        = ov_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    conv_in_d        = bus.ch_data[grant_idx*DW +: DW];
                    ack_d[grant_idx] = 1'b1;
                    conv_en_d        = 1'b1;
                    cnt_d            = CNT_W'(SETTLE_CYC);
                    last_d           = grant_idx;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    out_data_d  = bus.conv_out;
                    out_ch_d    = last_q;
                    out_valid_d = 1'b1;
                    conv_en_d   = 1'b0;
                    if (ov_hit) begin
                        ov_d[last_q] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                conv_en_d   = 1'b0;
            end
        endcase
    end

    assign bus.ch_ack    = ack_q;
    assign bus.conv_en   = conv_en_q;
    assign bus.conv_in   = conv_in_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.ov_fault  = ov_q;

endmodule

// File: tb/tb_converter_channel_scheduler.sv
// Directed bench for converter_channel_scheduler (NCH=4, DW=8, SETTLE_CYC=4).
// The converter is modelled as conv_out = conv_in ^ 8'h15 unless overridden.
module tb_converter_channel_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic       force_en  = 1'b0;
    logic [7:0] force_val = 8'h00;

`ifdef CONV_SCHED_OV_GUARD_EN
    localparam logic [3:0] EXP_OV  = 4'b0100;
    localparam logic       EXP_ACK = 1'b0;
`else
    localparam logic [3:0] EXP_OV  = 4'b0000;
    localparam logic       EXP_ACK = 1'b1;
`endif

    converter_channel_scheduler_if #(.NCH(4), .DW(8)) bus ();

    converter_channel_scheduler #(.NCH(4), .DW(8), .SETTLE_CYC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.conv_out = force_en ? force_val : (bus.conv_in ^ 8'h15);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(bus.out_valid), 32'd1);
    endtask

    initial begin
        logic       stable;
        logic       acked;
        logic [7:0] held;
        int         t_prev;

        bus.ch_req    = 4'b0000;
        bus.ch_data   = {8'h33, 8'h22, 8'h11, 8'h40};
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_valid",  32'(bus.out_valid), 32'd0);
        check("rst_busy",   32'(bus.busy),      32'd0);
        check("rst_ack",    32'(bus.ch_ack),    32'd0);
        check("rst_conv_en",32'(bus.conv_en),   32'd0);
        check("rst_conv_in",32'(bus.conv_in),   32'd0);
        check("rst_ov",     32'(bus.ov_fault),  32'd0);

        // Single transaction on ch0 with exact latency.
        bus.ch_req = 4'b0001;
        tick();
        check("single_ack",     32'(bus.ch_ack),  32'b0001);
        check("single_conv_en", 32'(bus.conv_en), 32'd1);
        check("single_conv_in", 32'(bus.conv_in), 32'h40);
        check("single_busy",    32'(bus.busy),    32'd1);
        bus.ch_req = 4'b0000;
        tick();
        check("single_ack_pulse", 32'(bus.ch_ack), 32'd0);
        tick();
        tick();
        tick();
        check("single_early", 32'(bus.out_valid), 32'd0);
        tick();
        check("single_valid",   32'(bus.out_valid), 32'd1);
        check("single_data",    32'(bus.out_data),  32'h55);
        check("single_ch",      32'(bus.out_ch),    32'd0);
        check("single_conv_off",32'(bus.conv_en),   32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("single_release", 32'(bus.out_valid), 32'd0);
        check("single_idle",    32'(bus.busy),      32'd0);

        // Late changes: drop request and change data one cycle after grant.
        bus.ch_req = 4'b0100;
        tick();
        check("late_ack",     32'(bus.ch_ack),  32'b0100);
        check("late_conv_in", 32'(bus.conv_in), 32'h22);
        bus.ch_req  = 4'b0000;
        bus.ch_data = {8'h33, 8'hAA, 8'h11, 8'h40};
        tick();
        check("late_conv_hold", 32'(bus.conv_in), 32'h22);
        wait_valid(20);
        check("late_data", 32'(bus.out_data), 32'h37);
        check("late_ch",   32'(bus.out_ch),   32'd2);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.ch_data   = {8'h33, 8'h22, 8'h11, 8'h40};

        // Backpressure: result held for 20 cycles while others keep requesting.
        bus.ch_req = 4'b0011;
        tick();
        check("bp_ack", 32'(bus.ch_ack), 32'b0001);
        wait_valid(20);
        check("bp_data", 32'(bus.out_data), 32'h55);
        check("bp_ch",   32'(bus.out_ch),   32'd0);
        held   = bus.out_data;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus.out_valid || bus.out_data != held || bus.out_ch != 2'd0 || bus.ch_ack != 4'b0000)
                stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        bus.ch_req    = 4'b0000;
        bus.out_ready = 1'b0;
        check("bp_release", 32'(bus.out_valid), 32'd0);

        // Reset in the middle of SETTLE.
        bus.ch_req = 4'b1000;
        tick();
        check("mid_ack", 32'(bus.ch_ack), 32'b1000);
        bus.ch_req = 4'b0000;
        tick();
        tick();
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy",    32'(bus.busy),    32'd0);
        check("mid_rst_conv_en", 32'(bus.conv_en), 32'd0);
        check("mid_rst_conv_in", 32'(bus.conv_in), 32'd0);
        check("mid_rst_valid",   32'(bus.out_valid), 32'd0);
        #3;
        rst = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid || bus.busy) stable = 1'b0;
        end
        check("mid_no_result", 32'(stable), 32'd1);

        // Round-robin under full load: ch0 first after reset, one result per 7 cycles.
        bus.ch_req    = 4'b1111;
        bus.out_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_valid(20);
            check($sformatf("rr_ch%0d", k), 32'(bus.out_ch), 32'(k % 4));
            if (k > 0) check($sformatf("rr_period%0d", k), 32'(cyc - t_prev), 32'd7);
            t_prev = cyc;
            if (k == 4) bus.ch_req = 4'b0000;
            tick();
        end
        check("rr_data_last", 32'(bus.out_data), 32'h55);
        bus.out_ready = 1'b0;
        tick();

        // Over-voltage on ch2.
        force_en   = 1'b1;
        force_val  = 8'd201;
        bus.ch_req = 4'b0100;
        tick();
        bus.ch_req = 4'b0000;
        wait_valid(20);
        check("ov_data", 32'(bus.out_data), 32'd201);
        check("ov_ch",   32'(bus.out_ch),   32'd2);
        check("ov_flag", 32'(bus.ov_fault), 32'(EXP_OV));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        force_en      = 1'b0;
        bus.ch_req    = 4'b0100;
        acked         = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.ch_ack != 4'b0000) acked = 1'b1;
        end
        bus.ch_req = 4'b0000;
        check("ov_mask_ack", 32'(acked), 32'(EXP_ACK));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
